// File: rtl/dsp_slice_pkg.sv
`default_nettype none
// dsp_slice_pkg: shared constants, control bundle and arithmetic helpers for the DSP slice.
package dsp_slice_pkg;

  localparam logic MODE_INDEP = 1'b0;
  localparam logic MODE_SUM   = 1'b1;

  // Widest value the saturate helper accepts; ACC_W+2 must not exceed this.
  localparam int SAT_MAX_W = 128;

  typedef struct packed {
    logic loadconst;
    logic accumulate;
    logic negate;
    logic sub;
    logic mode;
    logic chain_sel;
  } ctrl_t;

  function automatic int prod_w(input int a, input int b);
    return a + b;
  endfunction

  // Clamp a signed value to the signed range of a w-bit result.
  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W-1:0] x,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
    lo = -hi - SAT_MAX_W'(1);
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mult_stage.sv
`default_nettype none
// dsp_mult_stage: registered full-precision signed A_W x B_W multiplier with clock enable.
module dsp_mult_stage
  import dsp_slice_pkg::*;
#(
  parameter int A_W = 18,
  parameter int B_W = 19
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic signed [A_W-1:0]               a,
  input  logic signed [B_W-1:0]               b,
  output logic signed [prod_w(A_W, B_W)-1:0]  p
);

  localparam int P_W = prod_w(A_W, B_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p <= '0;
    end else if (enable) begin
      p <= P_W'(a) * P_W'(b);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsp_slice_pipelined.sv
`default_nettype none
// dsp_slice_pipelined: 3-stage signed DSP slice (dual multiply, or MAC with cascade input).
// Define DSP_SLICE_SAT_EN to saturate mode-1 results instead of wrapping.
module dsp_slice_pipelined
  import dsp_slice_pkg::*;
#(
  parameter int A_W         = 18,
  parameter int B_W         = 19,
  parameter int ACC_W       = 64,
  parameter int CONST_SHIFT = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                in_valid,
  input  logic                                loadconst,
  input  logic                                accumulate,
  input  logic                                negate,
  input  logic                                sub,
  input  logic                                mode,
  input  logic                                chain_sel,
  input  logic signed [A_W-1:0]               ax,
  input  logic signed [B_W-1:0]               ay,
  input  logic signed [A_W-1:0]               bx,
  input  logic signed [B_W-1:0]               by,
  input  logic signed [ACC_W-1:0]             chainin,
  output logic                                out_valid,
  output logic signed [ACC_W-1:0]             resulta,
  output logic signed [prod_w(A_W, B_W)-1:0]  resultb,
  output logic signed [ACC_W-1:0]             chainout,
  output logic                                overflow
);

  localparam int P_W = prod_w(A_W, B_W);
  localparam int S_W = ACC_W + 2;

  ctrl_t                 in_ctrl;
  ctrl_t                 s1_ctrl;
  ctrl_t                 s2_ctrl;
  logic                  s1_valid;
  logic                  s2_valid;
  logic signed [A_W-1:0] s1_ax;
  logic signed [A_W-1:0] s1_bx;
  logic signed [B_W-1:0] s1_ay;
  logic signed [B_W-1:0] s1_by;
  logic signed [P_W-1:0] p0;
  logic signed [P_W-1:0] p1;

  assign in_ctrl = '{loadconst: loadconst, accumulate: accumulate, negate: negate,
                     sub: sub, mode: mode, chain_sel: chain_sel};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_ax    <= '0;
      s1_ay    <= '0;
      s1_bx    <= '0;
      s1_by    <= '0;
      s2_valid <= 1'b0;
      s2_ctrl  <= '0;
    end else if (enable) begin
      s1_valid <= in_valid;
      s1_ctrl  <= in_ctrl;
      s1_ax    <= ax;
      s1_ay    <= ay;
      s1_bx    <= bx;
      s1_by    <= by;
      s2_valid <= s1_valid;
      s2_ctrl  <= s1_ctrl;
    end
  end

  dsp_mult_stage #(.A_W(A_W), .B_W(B_W)) u_mult0 (
    .clk(clk), .reset(reset), .enable(enable), .a(s1_ax), .b(s1_ay), .p(p0)
  );

  dsp_mult_stage #(.A_W(A_W), .B_W(B_W)) u_mult1 (
    .clk(clk), .reset(reset), .enable(enable), .a(s1_bx), .b(s1_by), .p(p1)
  );

  logic signed [S_W-1:0]   prod_sum;
  logic signed [S_W-1:0]   term;
  logic signed [S_W-1:0]   base;
  logic signed [S_W-1:0]   chain_term;
  logic signed [S_W-1:0]   total;
  logic signed [ACC_W-1:0] next_a;
  logic signed [P_W-1:0]   next_b;
  logic                    next_ovf;

`ifdef DSP_SLICE_SAT_EN
  logic signed [SAT_MAX_W-1:0] sat_in;
  logic signed [SAT_MAX_W-1:0] sat_out;

  assign sat_in  = SAT_MAX_W'(total);
  assign sat_out = saturate(sat_in, ACC_W);
`else
  // Guard bits are only needed for clamping; wrapping discards them.
  logic unused_total_hi;
  assign unused_total_hi = ^total[S_W-1:ACC_W];
`endif

  always_comb begin
    prod_sum = s2_ctrl.sub ? (S_W'(p0) - S_W'(p1)) : (S_W'(p0) + S_W'(p1));
    term     = s2_ctrl.negate ? -prod_sum : prod_sum;
    if (s2_ctrl.accumulate)     base = S_W'(resulta);
    else if (s2_ctrl.loadconst) base = S_W'(1) <<< CONST_SHIFT;
    else                        base = '0;
    chain_term = s2_ctrl.chain_sel ? S_W'(chainin) : '0;
    total      = term + base + chain_term;

    next_a   = ACC_W'(p0);
    next_b   = p1;
    next_ovf = 1'b0;
    if (s2_ctrl.mode == MODE_SUM) begin
      next_b = '0;
`ifdef DSP_SLICE_SAT_EN
      next_a   = sat_out[ACC_W-1:0];
      next_ovf = (sat_out != sat_in);
`else
      next_a   = total[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      resulta   <= '0;
      resultb   <= '0;
      overflow  <= 1'b0;
    end else if (enable) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        resulta  <= next_a;
        resultb  <= next_b;
        overflow <= next_ovf;
      end
    end
  end

  assign chainout = resulta;

endmodule
`default_nettype wire

// File: tb/tb_dsp_slice_pipelined.sv
`default_nettype none
// tb_dsp_slice_pipelined: directed and randomized checks of the DSP slice against a sample-level model.
module tb_dsp_slice_pipelined;

  localparam int A_W         = 18;
  localparam int B_W         = 19;
  localparam int ACC_W       = 40;
  localparam int CONST_SHIFT = 4;
  localparam int P_W         = A_W + B_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    in_valid;
  logic                    loadconst;
  logic                    accumulate;
  logic                    negate;
  logic                    sub;
  logic                    mode;
  logic                    chain_sel;
  logic signed [A_W-1:0]   ax;
  logic signed [B_W-1:0]   ay;
  logic signed [A_W-1:0]   bx;
  logic signed [B_W-1:0]   by;
  logic signed [ACC_W-1:0] chainin;
  logic                    out_valid;
  logic signed [ACC_W-1:0] resulta;
  logic signed [P_W-1:0]   resultb;
  logic signed [ACC_W-1:0] chainout;
  logic                    overflow;

  dsp_slice_pipelined #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CONST_SHIFT(CONST_SHIFT)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .loadconst(loadconst), .accumulate(accumulate), .negate(negate), .sub(sub),
    .mode(mode), .chain_sel(chain_sel), .ax(ax), .ay(ay), .bx(bx), .by(by),
    .chainin(chainin), .out_valid(out_valid), .resulta(resulta), .resultb(resultb),
    .chainout(chainout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     vld, en, mode, lc, acc, neg, sb, cs;
    longint ax, ay, bx, by, chain;
  } smp_t;

  typedef struct {
    longint due;
    longint ra;
    longint rb;
    longint ov;
  } exp_t;

  int     passed   = 0;
  int     total    = 0;
  longint en_count = 0;
  longint acc_model = 0;
  longint chain_hist [2] = '{0, 0};
  exp_t   q [$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input longint req);
    total = total + 1;
    assert (obs === req) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
  endtask

  function automatic longint sext(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint rnd(input int w);
    longint r;
    r = longint'({$urandom(), $urandom()});
    return sext(r, w);
  endfunction

  function automatic smp_t mk(bit vld, bit en, bit md, bit lc, bit ac, bit ng, bit sb, bit cs,
                              longint a0, longint a1, longint b0, longint b1, longint ch);
    smp_t s;
    s.vld = vld; s.en = en; s.mode = md; s.lc = lc; s.acc = ac; s.neg = ng; s.sb = sb; s.cs = cs;
    s.ax = a0; s.ay = a1; s.bx = b0; s.by = b1; s.chain = ch;
    return s;
  endfunction

  // Sample-level reference: each accepted sample yields one result 3 enabled edges later.
  task automatic model(input smp_t s);
    exp_t   e;
    longint p0, p1, sm, r, hi, lo;
    p0 = s.ax * s.ay;
    p1 = s.bx * s.by;
    e.due = en_count + 3;
    e.ov  = 0;
    if (!s.mode) begin
      e.ra = p0;
      e.rb = p1;
    end else begin
      sm = s.sb ? p0 - p1 : p0 + p1;
      if (s.neg) sm = -sm;
      r = sm + (s.acc ? acc_model : (s.lc ? (64'sd1 <<< CONST_SHIFT) : 0)) + (s.cs ? s.chain : 0);
      hi = (64'sd1 <<< (ACC_W - 1)) - 1;
      lo = -hi - 1;
`ifdef DSP_SLICE_SAT_EN
      if (r > hi)      begin e.ra = hi; e.ov = 1; end
      else if (r < lo) begin e.ra = lo; e.ov = 1; end
      else             e.ra = r;
`else
      e.ra = sext(r, ACC_W);
`endif
      e.rb = 0;
    end
    acc_model = e.ra;
    q.push_back(e);
  endtask

  task automatic drive(input smp_t s);
    exp_t e;
    bit   exp_v;
    enable     = s.en;
    in_valid   = s.vld;
    mode       = s.mode;
    loadconst  = s.lc;
    accumulate = s.acc;
    negate     = s.neg;
    sub        = s.sb;
    chain_sel  = s.cs;
    ax         = A_W'(s.ax);
    ay         = B_W'(s.ay);
    bx         = A_W'(s.bx);
    by         = B_W'(s.by);
    chainin    = ACC_W'(chain_hist[1]);
    if (s.en && s.vld) model(s);
    @(posedge clk);
    #1;
    if (s.en) begin
      chain_hist[1] = chain_hist[0];
      chain_hist[0] = s.chain;
      en_count = en_count + 1;
      exp_v = (q.size() > 0) && (q[0].due == en_count);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
        e = q.pop_front();
        chk("resulta", resulta, e.ra);
        chk("resultb", resultb, e.rb);
        chk("chainout", chainout, e.ra);
        chk("overflow", overflow, e.ov);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(mk(0, 1, 0, 0, 0, 0, 0, 0, rnd(A_W), rnd(B_W), rnd(A_W), rnd(B_W), rnd(ACC_W)));
  endtask

  task automatic reset_pulse(input int n);
    reset = 1'b0;
    #1;
    chk("rst_resulta", resulta, 0);
    chk("rst_resultb", resultb, 0);
    chk("rst_chainout", chainout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_valid", out_valid, 0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_resulta", resulta, 0);
    q.delete();
    acc_model  = 0;
    chain_hist = '{0, 0};
    reset = 1'b1;
  endtask

  initial begin
    smp_t s;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; loadconst = 1'b0; accumulate = 1'b0;
    negate = 1'b0; sub = 1'b0; mode = 1'b0; chain_sel = 1'b0;
    ax = '0; ay = '0; bx = '0; by = '0; chainin = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse(2);
    idle(2);

    // Mode 0: independent products, single-cycle out_valid
    drive(mk(1, 1, 0, 1, 1, 1, 1, 1, 3, -5, 7, 11, 0));
    idle(4);
    chk("t1_resulta", resulta, -15);
    chk("t1_resultb", resultb, 77);

    // Mode 1 sum / difference / negate
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 100, 200, -50, 40, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 1, 0, 100, 200, -50, 40, 0));
    drive(mk(1, 1, 1, 0, 0, 1, 0, 0, 100, 200, -50, 40, 0));
    idle(4);
    chk("t2_resulta", resulta, -18000);

    // Rounding constant then accumulation across an in_valid gap
    drive(mk(1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 0));
    drive(mk(1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
    drive(mk(1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
    idle(2);
    drive(mk(1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
    drive(mk(1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
    idle(4);
    chk("t3_resulta", resulta, 20);

    // Cascade input
    drive(mk(1, 1, 1, 0, 0, 0, 0, 1, 100, 200, -50, 40, 1000));
    idle(4);
    chk("t4_resulta", resulta, 19000);
    chk("t4_chainout", chainout, 19000);

    // Accumulator overflow: 8 x 2^36 reaches 2^39
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      drive(mk(1, 1, 1, 0, 1, 0, 0, 0, -131072, -262144, -131072, -262144, 0));
    idle(4);
`ifdef DSP_SLICE_SAT_EN
    chk("t5_resulta", resulta, 64'sd549755813887);
    chk("t5_overflow", overflow, 1);
`else
    chk("t5_resulta", resulta, -64'sd549755813888);
    chk("t5_overflow", overflow, 0);
`endif

    // Stall mid-stream: a held sample must be accepted exactly once
    for (int i = 0; i < 6; i++) begin
      s = mk(1, 1, 1, 0, 1, 0, i[0], 1, rnd(A_W), rnd(B_W), rnd(A_W), rnd(B_W), rnd(20));
      if (i == 3) begin
        s.en = 0;
        repeat (3) drive(s);
        s.en = 1;
      end
      drive(s);
    end
    idle(5);
    chk("t6_drained", q.size(), 0);

    // Reset with two samples in flight
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 500, 500, 1, 1, 0));
    drive(mk(1, 1, 1, 0, 1, 0, 0, 0, 500, 500, 1, 1, 0));
    reset_pulse(3);
    idle(4);
    chk("t6_post_rst_resulta", resulta, 0);
    drive(mk(1, 1, 1, 0, 1, 0, 0, 0, 2, 3, 0, 0, 0));
    idle(4);
    chk("t6_first_after_rst", resulta, 6);

    // Randomized traffic with bubbles and stalls
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom_range(3) != 0), ($urandom_range(6) != 0), $urandom_range(1),
             $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
             $urandom_range(1), rnd(A_W), rnd(B_W), rnd(A_W), rnd(B_W),
             ($urandom_range(7) == 0) ? rnd(ACC_W) : rnd(24));
      drive(s);
    end
    idle(5);
    chk("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
